// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: two pipeline registers (M, WB) around a
// single-port data memory, register-file write-port generation, M-stage
// forwarding information and a sticky halt indication.
module mem_wb_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          CLOCK,
  input  logic          CLEAR,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_upper,
  input  logic [DW-1:0] ex_lower,
  input  logic [DW-1:0] ex_data1,
  input  logic [DW-1:0] ex_data2,
  input  logic [3:0]    ex_rd,
  input  logic [3:0]    ex_rs,
  input  logic [1:0]    ex_wdst,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic          ex_halt,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w15,
  output logic [1:0]    WRITEDST,
  output logic [3:0]    wb_rd,
  output logic [3:0]    wb_rs,
  output logic          fwd_m_valid,
  output logic          fwd_m_load,
  output logic [3:0]    fwd_m_rd,
  output logic [DW-1:0] fwd_m_value,
  output logic          halted
);

  localparam logic [1:0] WdNone = 2'b00;
  localparam logic [1:0] WdRd   = 2'b01;
  localparam logic [1:0] WdR15  = 2'b10;
  localparam logic [1:0] WdSwap = 2'b11;

  // M-stage registers
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_upper_q, m_lower_q, m_data1_q, m_data2_q;
  logic [3:0]    m_rd_q, m_rs_q;
  logic [1:0]    m_wdst_q, m_wdst_d;
  logic          m_load_q, m_load_d;
  logic          m_store_q, m_store_d;
  logic          m_halt_q;
  logic          halt_seen_q, halt_seen_d;

  // WB-stage registers
  logic          wb_valid_q;
  logic [DW-1:0] wb_upper_q, wb_lower_q, wb_data1_q, wb_data2_q, wb_rdata_q;
  logic [3:0]    wb_rd_q, wb_rs_q;
  logic [1:0]    wb_wdst_q;
  logic          wb_load_q;
  logic          halted_q;

  // Data memory; deliberately not reset so contents survive CLEAR.
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] m_addr;

  assign m_addr = m_lower_q[AW-1:0];

  // M capture decode: stores and halts never write the register file,
  // and a simultaneous read+write request is a store only.
  always_comb begin
    m_valid_d   = ex_valid & ~halt_seen_q;
    m_store_d   = ex_mem_wr;
    m_load_d    = ex_mem_rd & ~ex_mem_wr;
    m_wdst_d    = (ex_mem_wr | ex_halt) ? WdNone : ex_wdst;
    halt_seen_d = halt_seen_q | (m_valid_d & ex_halt);
  end

  // M pipeline register and halt tracking
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      m_valid_q   <= 1'b0;
      m_upper_q   <= '0;
      m_lower_q   <= '0;
      m_data1_q   <= '0;
      m_data2_q   <= '0;
      m_rd_q      <= '0;
      m_rs_q      <= '0;
      m_wdst_q    <= WdNone;
      m_load_q    <= 1'b0;
      m_store_q   <= 1'b0;
      m_halt_q    <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_upper_q   <= ex_upper;
      m_lower_q   <= ex_lower;
      m_data1_q   <= ex_data1;
      m_data2_q   <= ex_data2;
      m_rd_q      <= ex_rd;
      m_rs_q      <= ex_rs;
      m_wdst_q    <= m_wdst_d;
      m_load_q    <= m_load_d;
      m_store_q   <= m_store_d;
      m_halt_q    <= ex_halt;
      halt_seen_q <= halt_seen_d;
    end
  end

  // Store port; only a valid M instruction may write, so reset discards stores
  always_ff @(posedge CLOCK) begin
    if (m_valid_q && m_store_q) begin
      mem_q[m_addr] <= m_data1_q;
    end
  end

  // WB pipeline register, load data capture and sticky halted flag
  always_ff @(posedge CLOCK or negedge CLEAR) begin
    if (!CLEAR) begin
      wb_valid_q <= 1'b0;
      wb_upper_q <= '0;
      wb_lower_q <= '0;
      wb_data1_q <= '0;
      wb_data2_q <= '0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
      wb_rs_q    <= '0;
      wb_wdst_q  <= WdNone;
      wb_load_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      wb_valid_q <= m_valid_q;
      wb_upper_q <= m_upper_q;
      wb_lower_q <= m_lower_q;
      wb_data1_q <= m_data1_q;
      wb_data2_q <= m_data2_q;
      wb_rd_q    <= m_rd_q;
      wb_rs_q    <= m_rs_q;
      wb_wdst_q  <= m_wdst_q;
      wb_load_q  <= m_load_q;
      if (m_valid_q && m_load_q) begin
        wb_rdata_q <= mem_q[m_addr];
      end
      if (m_valid_q && m_halt_q) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Register-file write ports; unused ports and an empty WB drive zero
  always_comb begin
    w1       = '0;
    w2       = '0;
    w15      = '0;
    WRITEDST = WdNone;
    wb_rd    = '0;
    wb_rs    = '0;
    if (wb_valid_q) begin
      WRITEDST = wb_wdst_q;
      wb_rd    = wb_rd_q;
      wb_rs    = wb_rs_q;
      case (wb_wdst_q)
        WdRd: begin
          w1 = wb_load_q ? wb_rdata_q : wb_lower_q;
        end
        WdR15: begin
          w1  = wb_load_q ? wb_rdata_q : wb_lower_q;
          w15 = wb_upper_q;
        end
        WdSwap: begin
          w1 = wb_data2_q;
          w2 = wb_data1_q;
        end
        default: ;
      endcase
    end
  end

  // Forwarding view of the M stage; a load's value is not ready yet
  always_comb begin
    fwd_m_valid = m_valid_q & (m_wdst_q != WdNone);
    fwd_m_load  = fwd_m_valid & m_load_q;
    fwd_m_rd    = m_rd_q;
    fwd_m_value = m_lower_q;
    halted      = halted_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a table of instructions with expected write-back
// results pushed to scoreboards when driven, plus hand-written reset sequences.
module tb_mem_wb_stage;

  logic        clk;
  logic        clear_n;
  logic        ex_valid;
  logic [15:0] ex_upper, ex_lower, ex_data1, ex_data2;
  logic [3:0]  ex_rd, ex_rs;
  logic [1:0]  ex_wdst;
  logic        ex_mem_rd, ex_mem_wr, ex_halt;
  logic [15:0] w1, w2, w15;
  logic [1:0]  writedst;
  logic [3:0]  wb_rd, wb_rs;
  logic        fwd_m_valid, fwd_m_load;
  logic [3:0]  fwd_m_rd;
  logic [15:0] fwd_m_value;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_wb_stage #(.DW(16), .AW(8), .DEPTH(256)) dut (
    .CLOCK      (clk),
    .CLEAR      (clear_n),
    .ex_valid   (ex_valid),
    .ex_upper   (ex_upper),
    .ex_lower   (ex_lower),
    .ex_data1   (ex_data1),
    .ex_data2   (ex_data2),
    .ex_rd      (ex_rd),
    .ex_rs      (ex_rs),
    .ex_wdst    (ex_wdst),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_halt    (ex_halt),
    .w1         (w1),
    .w2         (w2),
    .w15        (w15),
    .WRITEDST   (writedst),
    .wb_rd      (wb_rd),
    .wb_rs      (wb_rs),
    .fwd_m_valid(fwd_m_valid),
    .fwd_m_load (fwd_m_load),
    .fwd_m_rd   (fwd_m_rd),
    .fwd_m_value(fwd_m_value),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] up, lo, d1, d2;
    logic [3:0]  rd, rs;
    logic [1:0]  wd;
    logic        mr, mw, h;
    logic [1:0]  ewd;
    logic [15:0] ew1, ew2, ew15;
    logic        eh, efv, efl;
  } vec_t;

  typedef struct {
    int   due;
    vec_t v;
  } sb_t;

  vec_t tbl [13];
  sb_t  wb_q [$];
  sb_t  fwd_q [$];

  function automatic vec_t mk(input logic v, input logic [15:0] up, input logic [15:0] lo,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic [3:0] rd, input logic [3:0] rs,
                              input logic [1:0] wd, input logic mr, input logic mw,
                              input logic h, input logic [1:0] ewd,
                              input logic [15:0] ew1, input logic [15:0] ew2,
                              input logic [15:0] ew15, input logic eh,
                              input logic efv, input logic efl);
    vec_t r;
    r.v = v; r.up = up; r.lo = lo; r.d1 = d1; r.d2 = d2; r.rd = rd; r.rs = rs;
    r.wd = wd; r.mr = mr; r.mw = mw; r.h = h; r.ewd = ewd; r.ew1 = ew1;
    r.ew2 = ew2; r.ew15 = ew15; r.eh = eh; r.efv = efv; r.efl = efl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    ex_valid  = r.v;  ex_upper  = r.up; ex_lower = r.lo;
    ex_data1  = r.d1; ex_data2  = r.d2; ex_rd    = r.rd;
    ex_rs     = r.rs; ex_wdst   = r.wd; ex_mem_rd = r.mr;
    ex_mem_wr = r.mw; ex_halt   = r.h;
  endtask

  task automatic check_due();
    sb_t e;
    while (fwd_q.size() > 0 && fwd_q[0].due == cyc) begin
      e = fwd_q.pop_front();
      chk("fwd_m_valid", 16'(fwd_m_valid), 16'(e.v.efv));
      chk("fwd_m_load", 16'(fwd_m_load), 16'(e.v.efl));
      if (e.v.efv) begin
        chk("fwd_m_rd", 16'(fwd_m_rd), 16'(e.v.rd));
        chk("fwd_m_value", fwd_m_value, e.v.lo);
      end
    end
    while (wb_q.size() > 0 && wb_q[0].due == cyc) begin
      e = wb_q.pop_front();
      chk("WRITEDST", 16'(writedst), 16'(e.v.ewd));
      chk("w1", w1, e.v.ew1);
      chk("w2", w2, e.v.ew2);
      chk("w15", w15, e.v.ew15);
      chk("halted", 16'(halted), 16'(e.v.eh));
      if (e.v.ewd != 2'b00) chk("wb_rd", 16'(wb_rd), 16'(e.v.rd));
      if (e.v.ewd == 2'b11) chk("wb_rs", 16'(wb_rs), 16'(e.v.rs));
    end
  endtask

  // Advance one cycle; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_due();
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    sb_t e;
    //             v  up       lo       d1       d2       rd rs wd     mr mw h  ewd    ew1      ew2      ew15     eh fv fl
    tbl[0]  = mk(1, 16'h00AB, 16'h1234, 16'h0000, 16'h0000, 3, 0, 2'b10, 0, 0, 0, 2'b10, 16'h1234, 16'h0000, 16'h00AB, 0, 1, 0);
    tbl[1]  = mk(1, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 9, 0, 2'b01, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(1, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 5, 0, 2'b01, 1, 0, 0, 2'b01, 16'hBEEF, 16'h0000, 16'h0000, 0, 1, 1);
    tbl[3]  = mk(1, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 1, 2, 2'b11, 0, 0, 0, 2'b11, 16'h0002, 16'h0001, 16'h0000, 0, 1, 0);
    tbl[4]  = mk(1, 16'h0000, 16'h0020, 16'h5555, 16'h0000, 8, 0, 2'b01, 1, 1, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 7, 0, 2'b01, 1, 0, 0, 2'b01, 16'h5555, 16'h0000, 16'h0000, 0, 1, 1);
    tbl[6]  = mk(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 4, 2'b01, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[7]  = mk(1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 15, 0, 2'b01, 0, 0, 0, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 0);
    tbl[8]  = mk(1, 16'h0042, 16'h0010, 16'h0000, 16'h0000, 4, 0, 2'b10, 1, 0, 0, 2'b10, 16'hBEEF, 16'h0000, 16'h0042, 0, 1, 1);
    tbl[9]  = mk(1, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 2, 0, 2'b01, 0, 0, 0, 2'b01, 16'h1111, 16'h0000, 16'h0000, 0, 1, 0);
    tbl[10] = mk(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6, 0, 2'b01, 0, 0, 1, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    tbl[11] = mk(1, 16'h0000, 16'h2222, 16'h0000, 16'h0000, 3, 0, 2'b01, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    tbl[12] = mk(1, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 4, 0, 2'b01, 1, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);

    // Reset held for two cycles with a valid instruction presented
    clear_n = 1'b0;
    drive(mk(1, 16'h00AB, 16'h0030, 16'h7777, 16'h0, 3, 1, 2'b01, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_WRITEDST", 16'(writedst), 16'h0);
      chk("rst_w1", w1, 16'h0);
      chk("rst_w2", w2, 16'h0);
      chk("rst_w15", w15, 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
    end

    // Table: one instruction per cycle, results due two edges later
    clear_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      e.v = tbl[i];
      e.due = cyc + 1;
      fwd_q.push_back(e);
      e.due = cyc + 2;
      wb_q.push_back(e);
      tick();
    end
    idle();
    tick();
    tick();
    chk("sb_drained", 16'(wb_q.size() + fwd_q.size()), 16'h0);
    chk("halted_sticky", 16'(halted), 16'h1);

    // Reset mid-flight: a load in M when CLEAR drops, store attempt during reset
    clear_n = 1'b0;
    tick();
    chk("halt_cleared", 16'(halted), 16'h0);
    clear_n = 1'b1;
    drive(mk(1, 16'h0, 16'h0010, 16'h0, 16'h0, 6, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tick();
    chk("mf_fwd_load", 16'(fwd_m_load), 16'h1);
    chk("mf_fwd_rd", 16'(fwd_m_rd), 16'h6);
    clear_n = 1'b0;
    drive(mk(1, 16'h0, 16'h0010, 16'hDEAD, 16'h0, 6, 0, 2'b01, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mf_async_fwd", 16'(fwd_m_valid), 16'h0);
    chk("mf_async_wdst", 16'(writedst), 16'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mf_WRITEDST", 16'(writedst), 16'h0);
      chk("mf_w1", w1, 16'h0);
      chk("mf_halted", 16'(halted), 16'h0);
    end
    clear_n = 1'b1;
    drive(mk(1, 16'h0, 16'h0010, 16'h0, 16'h0, 5, 0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    tick();
    idle();
    tick();
    chk("rb_WRITEDST", 16'(writedst), 16'h1);
    chk("rb_w1", w1, 16'hBEEF);
    chk("rb_wb_rd", 16'(wb_rd), 16'h5);
    chk("rb_halted", 16'(halted), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
